// File: rtl/bus_port_pkg.sv
// Shared defaults and sizing helpers for the per-driver bus port buffers.
package bus_port_pkg;

  localparam int DEFAULT_PCKG_SZ = 16;
  localparam int DEFAULT_DEPTH   = 8;

  // Occupancy counter width: one extra bit so the count can reach depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bus_port_sync_fifo.sv
// Circular-buffer FIFO with show-ahead head, sticky overflow and
// full-queue write+read pass-through. Used for both TX and RX directions.
//
// Handshake: wr is a push request (no ready; the write is dropped and ovf
// set if the queue is full and no read is accepted in the same cycle);
// rd is a pop request, honoured only while pending=1. rd_data is valid
// whenever pending=1 and reads as 0 when the queue is empty.
module bus_port_sync_fifo
  import bus_port_pkg::*;
#(
  parameter int pckg_sz = DEFAULT_PCKG_SZ,
  parameter int depth   = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [pckg_sz-1:0] wr_data,
  input  logic               rd,
  output logic [pckg_sz-1:0] rd_data,
  output logic               pending,
  output logic               full,
  output logic               ovf
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = cnt_w(depth);

  logic [pckg_sz-1:0] mem_q [depth];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               empty, is_full;
  logic               do_rd, do_wr;

  assign empty   = (cnt_q == '0);
  assign is_full = (cnt_q == CNT_W'(depth));

  // Accept decisions and next-state pointers/count/overflow.
  always_comb begin
    do_rd    = rd && !empty;
    // A full queue still accepts a write when a read frees a slot this cycle.
    do_wr    = wr && (!is_full || do_rd);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    if (wr && !do_wr) ovf_d = 1'b1;
  end

  // Control state register; reset discards contents by zeroing the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; unreset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign pending = !empty;
  assign full    = is_full;
  assign ovf     = ovf_q;

endmodule

// File: rtl/bus_port_fifo.sv
// Per-driver port buffer: TX queue from the device to the bus arbiter and
// RX queue from the arbiter back to the device. Pure wiring of two FIFOs.
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int pckg_sz = DEFAULT_PCKG_SZ,
  parameter int depth   = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dev_push,
  input  logic [pckg_sz-1:0] dev_D_in,
  output logic               dev_full,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  output logic               pndng,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               dev_pop,
  output logic [pckg_sz-1:0] dev_D_out,
  output logic               dev_pndng,
  output logic               tx_ovf,
  output logic               rx_ovf
);

  logic rx_full_unused;

  bus_port_sync_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr      (dev_push),
    .wr_data (dev_D_in),
    .rd      (pop),
    .rd_data (D_pop),
    .pending (pndng),
    .full    (dev_full),
    .ovf     (tx_ovf)
  );

  bus_port_sync_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr      (push),
    .wr_data (D_push),
    .rd      (dev_pop),
    .rd_data (dev_D_out),
    .pending (dev_pndng),
    .full    (rx_full_unused),
    .ovf     (rx_ovf)
  );

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo: reset, TX ordering, full/overflow,
// wrap-around, RX empty write+read, RX overflow, reset with live contents.
module tb_bus_port_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk;
  logic         reset;
  logic         dev_push;
  logic [W-1:0] dev_D_in;
  logic         dev_full;
  logic         pop;
  logic [W-1:0] D_pop;
  logic         pndng;
  logic         push;
  logic [W-1:0] D_push;
  logic         dev_pop;
  logic [W-1:0] dev_D_out;
  logic         dev_pndng;
  logic         tx_ovf;
  logic         rx_ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  bus_port_fifo #(.pckg_sz(W), .depth(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_push  (dev_push),
    .dev_D_in  (dev_D_in),
    .dev_full  (dev_full),
    .pop       (pop),
    .D_pop     (D_pop),
    .pndng     (pndng),
    .push      (push),
    .D_push    (D_push),
    .dev_pop   (dev_pop),
    .dev_D_out (dev_D_out),
    .dev_pndng (dev_pndng),
    .tx_ovf    (tx_ovf),
    .rx_ovf    (rx_ovf)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1; dev_push = 1'b0; dev_D_in = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; dev_pop = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_pndng", pndng, 0);
    check("rst_D_pop", D_pop, 0);
    check("rst_dev_pndng", dev_pndng, 0);
    check("rst_dev_D_out", dev_D_out, 0);
    check("rst_dev_full", dev_full, 0);
    check("rst_tx_ovf", tx_ovf, 0);
    check("rst_rx_ovf", rx_ovf, 0);

    // Three consecutive writes, then three pops in order
    dev_push = 1'b1; dev_D_in = 16'h0101;
    tick();
    check("wr1_pndng", pndng, 1);
    check("wr1_head", D_pop, 16'h0101);
    dev_D_in = 16'h0202; tick();
    dev_D_in = 16'h0303; tick();
    dev_push = 1'b0;
    exp_q = '{16'h0101, 16'h0202, 16'h0303};
    pop = 1'b1;
    while (exp_q.size() > 0) begin
      check("tx_order", D_pop, exp_q.pop_front());
      tick();
    end
    pop = 1'b0;
    check("tx_drained_pndng", pndng, 0);
    check("tx_drained_D_pop", D_pop, 0);

    // Fill TX to depth
    dev_push = 1'b1;
    for (int i = 0; i < D; i++) begin
      dev_D_in = W'(16'h0010 + i);
      tick();
      check("fill_dev_full", dev_full, (i == D - 1) ? 1 : 0);
    end
    check("fill_tx_ovf", tx_ovf, 0);
    // Ninth write is dropped
    dev_D_in = 16'hDEAD;
    tick();
    check("ovf_tx_ovf", tx_ovf, 1);
    check("ovf_head", D_pop, 16'h0010);
    check("ovf_dev_full", dev_full, 1);
    // Write and pop while full: both performed, still full
    dev_D_in = 16'h0099; pop = 1'b1;
    tick();
    dev_push = 1'b0;
    check("full_wr_rd_dev_full", dev_full, 1);
    check("full_wr_rd_tx_ovf", tx_ovf, 1);
    check("full_wr_rd_head", D_pop, 16'h0011);
    // Drain: 0x11..0x17 then 0x99, proving count stayed at depth
    for (int i = 1; i < D; i++) exp_q.push_back(W'(16'h0010 + i));
    exp_q.push_back(16'h0099);
    for (int i = 0; i < D; i++) begin
      check("drain_head", D_pop, exp_q.pop_front());
      tick();
      if (i == 0) check("drain_dev_full_clear", dev_full, 0);
    end
    pop = 1'b0;
    check("drain_pndng", pndng, 0);
    check("drain_D_pop", D_pop, 0);

    // 20 write/read cycles across pointer wrap
    dev_push = 1'b1; pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dev_D_in = W'(i);
      tick();
      check("wrap_head", D_pop, i);
      check("wrap_pndng", pndng, 1);
      check("wrap_dev_full", dev_full, 0);
    end
    dev_push = 1'b0;
    tick();
    pop = 1'b0;
    check("wrap_end_pndng", pndng, 0);

    // RX: push and dev_pop together while empty
    push = 1'b1; D_push = 16'h07AA; dev_pop = 1'b1;
    tick();
    push = 1'b0; dev_pop = 1'b0;
    check("rx_empty_wr_rd_pndng", dev_pndng, 1);
    check("rx_empty_wr_rd_head", dev_D_out, 16'h07AA);
    check("rx_tx_indep", pndng, 0);
    dev_pop = 1'b1;
    tick();
    dev_pop = 1'b0;
    check("rx_pop_pndng", dev_pndng, 0);
    check("rx_pop_head", dev_D_out, 0);
    // Nine pushes without dev_pop
    push = 1'b1;
    for (int i = 0; i < D + 1; i++) begin
      D_push = W'(16'h0100 + i);
      tick();
      check("rx_fill_ovf", rx_ovf, (i == D) ? 1 : 0);
    end
    push = 1'b0;
    check("rx_ovf_head", dev_D_out, 16'h0100);

    // Reset with 5 TX entries and a concurrent dev_push
    dev_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dev_D_in = W'(16'h0A00 + i);
      tick();
    end
    check("pre_rst_pndng", pndng, 1);
    reset = 1'b1; dev_D_in = 16'h5555;
    tick();
    check("rst2_pndng", pndng, 0);
    check("rst2_D_pop", D_pop, 0);
    check("rst2_tx_ovf", tx_ovf, 0);
    check("rst2_rx_ovf", rx_ovf, 0);
    check("rst2_dev_pndng", dev_pndng, 0);
    check("rst2_dev_full", dev_full, 0);
    reset = 1'b0; dev_push = 1'b0;
    tick();
    check("post_rst_pndng", pndng, 0);
    // Queue usable again after reset
    dev_push = 1'b1; dev_D_in = 16'h1234;
    tick();
    dev_push = 1'b0;
    check("post_rst_head", D_pop, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
